// File: rtl/victim_cache_pkg.sv
// rtl/victim_cache_pkg.sv - state encoding and width helper shared by the victim cache blocks
package victim_cache_pkg;

    typedef logic [2:0] vc_state_t;

    localparam vc_state_t IDLE      = 3'd0;
    localparam vc_state_t READ_HIT  = 3'd1;
    localparam vc_state_t READ_MISS = 3'd2;
    localparam vc_state_t WB        = 3'd3;
    localparam vc_state_t FILL      = 3'd4;

    function automatic int tag_width(input int addr_w, input int offset_w);
        return addr_w - offset_w;
    endfunction

endpackage

// File: rtl/victim_cache_lru.sv
// rtl/victim_cache_lru.sv - true-LRU age registers for the victim cache
// Ages always form a permutation of 0..ENTRIES-1; the oldest entry is the replacement candidate.
module victim_cache_lru #(
    parameter int ENTRIES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       touch,
    input  logic [$clog2(ENTRIES)-1:0] touch_idx,
    output logic [$clog2(ENTRIES)-1:0] lru_idx
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] age [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age[i] <= IDX_W'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    age[i] <= '0;
                end else if (age[i] < age[touch_idx]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age[i] == IDX_W'(ENTRIES - 1)) begin
                lru_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache_nway_control.sv
// rtl/victim_cache_nway_control.sv - fully-associative write-back victim cache between L2 and memory
// Optional performance counters are built when VC_PERF_COUNTER_EN is defined.
module victim_cache_nway_control
    import victim_cache_pkg::*;
#(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_vc_read,
    input  logic              l2_vc_write,
    input  logic [ADDR_W-1:0] l2_vc_address,
    input  logic [LINE_W-1:0] l2_vc_wdata,
    input  logic              l2_vc_wdirty,
    output logic [LINE_W-1:0] l2_vc_rdata,
    output logic              l2_vc_rdirty,
    output logic              l2_vc_resp,
    output logic              vc_pmem_read,
    output logic              vc_pmem_write,
    output logic [ADDR_W-1:0] vc_pmem_address,
    output logic [LINE_W-1:0] vc_pmem_wdata,
`ifdef VC_PERF_COUNTER_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count,
`endif
    input  logic [LINE_W-1:0] vc_pmem_rdata,
    input  logic              vc_pmem_resp
);

    localparam int TAG_W = tag_width(ADDR_W, OFFSET_W);
    localparam int IDX_W = $clog2(ENTRIES);

    vc_state_t          state;
    logic [IDX_W-1:0]   slot;
    logic               fill_dirty;
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] dirty;
    logic [TAG_W-1:0]   tags  [ENTRIES];
    logic [LINE_W-1:0]  lines [ENTRIES];

    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               have_free;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   lru_idx;
    logic [IDX_W-1:0]   victim_idx;
    logic               unused_offset;

    assign req_tag       = l2_vc_address[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^l2_vc_address[OFFSET_W-1:0];

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tags[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        // Descending scan so the lowest-index free slot wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign victim_idx = have_free ? free_idx : lru_idx;

    victim_cache_lru #(
        .ENTRIES(ENTRIES)
    ) u_lru (
        .clk      (clk),
        .rst      (rst),
        .touch    (state == FILL),
        .touch_idx(slot),
        .lru_idx  (lru_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= '0;
            fill_dirty <= 1'b0;
            valid      <= '0;
            dirty      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (l2_vc_write) begin
                        if (hit) begin
                            slot       <= hit_idx;
                            fill_dirty <= dirty[hit_idx] | l2_vc_wdirty;
                            state      <= FILL;
                        end else begin
                            slot       <= victim_idx;
                            fill_dirty <= l2_vc_wdirty;
                            state      <= (valid[victim_idx] && dirty[victim_idx]) ? WB : FILL;
                        end
                    end else if (l2_vc_read) begin
                        slot  <= hit_idx;
                        state <= hit ? READ_HIT : READ_MISS;
                    end
                end
                READ_HIT: begin
                    valid[slot] <= 1'b0;
                    state       <= IDLE;
                end
                READ_MISS: begin
                    if (vc_pmem_resp) state <= IDLE;
                end
                WB: begin
                    if (vc_pmem_resp) state <= FILL;
                end
                FILL: begin
                    valid[slot] <= 1'b1;
                    dirty[slot] <= fill_dirty;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tags[slot]  <= req_tag;
            lines[slot] <= l2_vc_wdata;
        end
    end

    always_comb begin
        l2_vc_rdata     = '0;
        l2_vc_rdirty    = 1'b0;
        l2_vc_resp      = 1'b0;
        vc_pmem_read    = 1'b0;
        vc_pmem_write   = 1'b0;
        vc_pmem_address = '0;
        vc_pmem_wdata   = '0;
        case (state)
            READ_HIT: begin
                l2_vc_rdata  = lines[slot];
                l2_vc_rdirty = dirty[slot];
                l2_vc_resp   = 1'b1;
            end
            READ_MISS: begin
                vc_pmem_read    = 1'b1;
                vc_pmem_address = {req_tag, {OFFSET_W{1'b0}}};
                l2_vc_rdata     = vc_pmem_rdata;
                l2_vc_resp      = vc_pmem_resp;
            end
            WB: begin
                vc_pmem_write   = 1'b1;
                vc_pmem_address = {tags[slot], {OFFSET_W{1'b0}}};
                vc_pmem_wdata   = lines[slot];
            end
            FILL: l2_vc_resp = 1'b1;
            default: ;
        endcase
    end

`ifdef VC_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == READ_HIT && hit_count != '1) hit_count <= hit_count + 1'b1;
            if (state == IDLE && !l2_vc_write && l2_vc_read && !hit && miss_count != '1)
                miss_count <= miss_count + 1'b1;
            if (state == WB && vc_pmem_resp && wb_count != '1) wb_count <= wb_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_victim_cache_nway_control.sv
// tb/tb_victim_cache_nway_control.sv - randomized bench checking the victim cache against a recency-list model
`timescale 1ns/1ps
module tb_victim_cache_nway_control;

    localparam int ENTRIES  = 4;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              l2_vc_read, l2_vc_write, l2_vc_wdirty;
    logic [ADDR_W-1:0] l2_vc_address;
    logic [LINE_W-1:0] l2_vc_wdata;
    logic [LINE_W-1:0] l2_vc_rdata;
    logic              l2_vc_rdirty, l2_vc_resp;
    logic              vc_pmem_read, vc_pmem_write;
    logic [ADDR_W-1:0] vc_pmem_address;
    logic [LINE_W-1:0] vc_pmem_wdata;
    logic [LINE_W-1:0] vc_pmem_rdata;
    logic              vc_pmem_resp;
`ifdef VC_PERF_COUNTER_EN
    logic [31:0]       hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

    victim_cache_nway_control #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)
    ) dut (
        .clk(clk), .rst(rst),
        .l2_vc_read(l2_vc_read), .l2_vc_write(l2_vc_write),
        .l2_vc_address(l2_vc_address), .l2_vc_wdata(l2_vc_wdata), .l2_vc_wdirty(l2_vc_wdirty),
        .l2_vc_rdata(l2_vc_rdata), .l2_vc_rdirty(l2_vc_rdirty), .l2_vc_resp(l2_vc_resp),
        .vc_pmem_read(vc_pmem_read), .vc_pmem_write(vc_pmem_write),
        .vc_pmem_address(vc_pmem_address), .vc_pmem_wdata(vc_pmem_wdata),
`ifdef VC_PERF_COUNTER_EN
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
        .vc_pmem_rdata(vc_pmem_rdata), .vc_pmem_resp(vc_pmem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-slot contents plus a recency list (front = most recent).
    logic        m_valid [ENTRIES];
    logic [31:0] m_addr  [ENTRIES];
    logic [255:0] m_data [ENTRIES];
    logic        m_dirty [ENTRIES];
    int          rq[$];
    int          m_hits, m_misses, m_wbs;

    logic [255:0] last_rdata, last_pwdata;
    logic         last_rdirty;
    logic [31:0]  last_paddr, model_wb_addr;

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return {8{a ^ 32'h5a5a_0000}};
    endfunction

    function automatic logic [255:0] pattern(input int n);
        logic [31:0] w;
        w = 32'hc0de_0000 + n;
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_resp, input logic e_pr, input logic e_pw,
                            input logic [31:0] e_paddr, input logic [255:0] e_pwdata,
                            input logic [255:0] e_rdata, input logic e_rdirty);
        chk({tag, ".resp"},   l2_vc_resp,      e_resp);
        chk({tag, ".pread"},  vc_pmem_read,    e_pr);
        chk({tag, ".pwrite"}, vc_pmem_write,   e_pw);
        chk({tag, ".paddr"},  vc_pmem_address, e_paddr);
        chk({tag, ".pwdata"}, vc_pmem_wdata,   e_pwdata);
        chk({tag, ".rdata"},  l2_vc_rdata,     e_rdata);
        chk({tag, ".rdirty"}, l2_vc_rdirty,    e_rdirty);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        rq.delete();
        for (int i = 0; i < ENTRIES; i++) rq.push_back(i);
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    task automatic touch(input int s);
        for (int i = 0; i < rq.size(); i++) begin
            if (rq[i] == s) begin
                rq.delete(i);
                break;
            end
        end
        rq.push_front(s);
    endtask

    task automatic drop_inputs();
        l2_vc_read = 1'b0; l2_vc_write = 1'b0; l2_vc_wdirty = 1'b0;
        l2_vc_address = '0; l2_vc_wdata = '0; vc_pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
`ifdef VC_PERF_COUNTER_EN
        chk("reset.hit_count", hit_count, 0);
        chk("reset.miss_count", miss_count, 0);
        chk("reset.wb_count", wb_count, 0);
`endif
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wd, input logic wdirty, input int delay);
        logic [31:0]  line;
        logic [255:0] prd;
        logic         wb, nd;
        int           h, slot;
        line = addr & 32'hffff_ffe0;
        h = -1;
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_addr[i] == line) h = i;
        @(posedge clk); #1;
        l2_vc_read = rd; l2_vc_write = wr; l2_vc_address = addr;
        l2_vc_wdata = wd; l2_vc_wdirty = wdirty;
        @(negedge clk);
        chk_outs("idle", 0, 0, 0, 0, 0, 0, 0);
        if (wr) begin
            if (h >= 0) begin
                slot = h;
                wb = 1'b0;
                nd = m_dirty[h] | wdirty;
            end else begin
                slot = -1;
                for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                if (slot < 0) slot = rq[rq.size() - 1];
                wb = m_valid[slot] && m_dirty[slot];
                nd = wdirty;
            end
            model_wb_addr = wb ? m_addr[slot] : 32'hffff_ffff;
            if (wb) begin
                for (int k = 0; k <= delay; k++) begin
                    @(posedge clk); #1;
                    vc_pmem_resp = (k == delay);
                    @(negedge clk);
                    chk_outs("wb", 0, 0, 1, m_addr[slot], m_data[slot], 0, 0);
                    last_paddr  = vc_pmem_address;
                    last_pwdata = vc_pmem_wdata;
                end
                m_wbs++;
            end
            @(posedge clk); #1;
            vc_pmem_resp = 1'b0;
            @(negedge clk);
            chk_outs("fill", 1, 0, 0, 0, 0, 0, 0);
            m_valid[slot] = 1'b1;
            m_addr[slot]  = line;
            m_data[slot]  = wd;
            m_dirty[slot] = nd;
            touch(slot);
        end else if (h >= 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_outs("rhit", 1, 0, 0, 0, 0, m_data[h], m_dirty[h]);
            last_rdata  = l2_vc_rdata;
            last_rdirty = l2_vc_rdirty;
            m_valid[h] = 1'b0;
            m_hits++;
        end else begin
            prd = mem_line(line);
            for (int k = 0; k <= delay; k++) begin
                @(posedge clk); #1;
                vc_pmem_rdata = prd;
                vc_pmem_resp  = (k == delay);
                @(negedge clk);
                chk_outs("rmiss", k == delay, 1, 0, line, 0, prd, 0);
                last_paddr  = vc_pmem_address;
                last_rdata  = l2_vc_rdata;
                last_rdirty = l2_vc_rdirty;
            end
            m_misses++;
        end
        @(posedge clk); #1;
        drop_inputs();
        @(negedge clk);
        chk_outs("post", 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_four(input logic d2);
        do_req(0, 1, 32'h00, pattern(0), 1'b1, 0);
        do_req(0, 1, 32'h20, pattern(1), 1'b1, 0);
        do_req(0, 1, 32'h40, pattern(2), d2, 0);
        do_req(0, 1, 32'h60, pattern(3), 1'b1, 0);
    endtask

    initial begin
        vc_pmem_rdata = '0;
        do_reset();

        // Clean write, read hit, then re-read misses because the line migrated out.
        do_req(0, 1, 32'h1000, pattern(16), 1'b0, 0);
        do_req(1, 0, 32'h1000, '0, 1'b0, 0);
        chk("lit.rhit_data", last_rdata, pattern(16));
        chk("lit.rhit_dirty", last_rdirty, 1'b0);
        do_req(1, 0, 32'h1007, '0, 1'b0, 2);
        chk("lit.rmiss_addr", last_paddr, 32'h1000);

        // Full of dirty lines; next allocation writes back the oldest (0x0).
        do_reset();
        fill_four(1'b1);
        do_req(0, 1, 32'h80, pattern(4), 1'b0, 3);
        chk("lit.wb_model_addr", model_wb_addr, 32'h0);
        chk("lit.wb_addr", last_paddr, 32'h0);
        chk("lit.wb_data", last_pwdata, pattern(0));

        // A write hit on 0x0 makes 0x20 the replacement candidate.
        do_reset();
        fill_four(1'b1);
        do_req(0, 1, 32'h00, pattern(5), 1'b0, 0);
        do_req(0, 1, 32'h80, pattern(6), 1'b0, 1);
        chk("lit.lru_victim", last_paddr, 32'h20);

        // Read and write together on a dirty resident line: write wins, dirty is ORed.
        do_req(1, 1, 32'h40, pattern(7), 1'b0, 0);
        do_req(1, 0, 32'h40, '0, 1'b0, 0);
        chk("lit.both_data", last_rdata, pattern(7));
        chk("lit.both_dirty", last_rdirty, 1'b1);

        // Reset in the middle of a write-back.
        do_reset();
        fill_four(1'b1);
        @(posedge clk); #1;
        l2_vc_write = 1'b1; l2_vc_address = 32'h80; l2_vc_wdata = pattern(8); l2_vc_wdirty = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstwb.pwrite_before", vc_pmem_write, 1'b1);
        #1 rst = 1'b1;
        #1 chk("rstwb.pwrite_drop", vc_pmem_write, 1'b0);
        drop_inputs();
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        do_req(1, 0, 32'h00, '0, 1'b0, 1);
        chk("lit.rstwb_miss_addr", last_paddr, 32'h0);
        chk("lit.rstwb_miss_data", last_rdata, mem_line(32'h0));

        // Two hits, three misses, one write-back.
        do_reset();
        fill_four(1'b1);
        do_req(0, 1, 32'h80, pattern(9), 1'b0, 0);
        do_req(1, 0, 32'h20, '0, 1'b0, 0);
        do_req(1, 0, 32'h40, '0, 1'b0, 0);
        do_req(1, 0, 32'h00, '0, 1'b0, 0);
        do_req(1, 0, 32'h20, '0, 1'b0, 1);
        do_req(1, 0, 32'h1000, '0, 1'b0, 0);
`ifdef VC_PERF_COUNTER_EN
        chk("lit.hit_count", hit_count, 2);
        chk("lit.miss_count", miss_count, 3);
        chk("lit.wb_count", wb_count, 1);
`endif

        // Random traffic over eight lines competing for four slots.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0]  a;
            logic [255:0] d;
            int           op;
            a  = 32'h0004_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            d  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            op = $urandom_range(0, 9);
            do_req(op >= 5, (op < 5) || (op == 9), a, d, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end
`ifdef VC_PERF_COUNTER_EN
        chk("rand.hit_count", hit_count, 32'(m_hits));
        chk("rand.miss_count", miss_count, 32'(m_misses));
        chk("rand.wb_count", wb_count, 32'(m_wbs));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
